// File: rtl/synth_input_pkg.sv
// Shared definitions for the input-conditioning blocks: edge-mode encodings
// and the helper that decides whether a level change is reported.
package synth_input_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
        logic q;
        q = 1'b0;
        case (mode)
            EDGE_RISE: q = new_level;
            EDGE_FALL: q = ~new_level;
            EDGE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Purpose: one channel of synchronize -> debounce -> edge pulse -> sticky pending/overrun.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from input change to level/pulse.
// Backpressure: none; events arriving while pending is set raise overrun.
module debounce_channel
    import synth_input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    input  logic ack,
    output logic level_out,
    output logic pulse_out,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] MODE = 2'(EDGE_MODE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   pulse_q;
    logic                   pending_q;
    logic                   overrun_q;
    logic                   synced;
    logic                   differ;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];
    assign differ = (synced != stable_q);
    assign accept = differ && ((int'(cnt_q) + 1) == DEBOUNCE_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Any edge where synced matches stable restarts the count, so glitches vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (!differ) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q    <= '0;
                stable_q <= synced;
                pulse_q  <= edge_qualifies(MODE, synced);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A pulse coinciding with ack re-arms pending and forgives the old overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (pulse_q) begin
            pending_q <= 1'b1;
            if (ack) begin
                overrun_q <= 1'b0;
            end else if (pending_q) begin
                overrun_q <= 1'b1;
            end
        end else if (ack && pending_q) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign level_out = stable_q;
    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/key_edge_detector.sv
// Purpose: NUM_CH independent debounced key channels with edge pulses and sticky events.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges; any_pending is combinational.
// Backpressure: none; unacknowledged repeat events set the per-channel overrun flag.
module key_edge_detector
    import synth_input_pkg::*;
#(
    parameter int NUM_CH          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    input  logic [NUM_CH-1:0] ack,
    output logic              any_pending
);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .EDGE_MODE      (EDGE_MODE)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .sig_in   (sig_in[i]),
                .ack      (ack[i]),
                .level_out(level_out[i]),
                .pulse_out(pulse_out[i]),
                .pending  (pending[i]),
                .overrun  (overrun[i])
            );
        end
    endgenerate

    assign any_pending = |pending;

endmodule

// File: tb/tb_key_edge_detector.sv
// Directed checks of key_edge_detector: default rising config, a both-edge
// short-debounce config, and a falling-edge three-stage config.
module tb_key_edge_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sig, lvl, pls, pnd, ovr, ack;
    logic       anyp;
    logic [3:0] sig2, lvl2, pls2, pnd2, ovr2, ack2;
    logic       anyp2;
    logic [0:0] sig3, lvl3, pls3, pnd3, ovr3, ack3;
    logic       anyp3;

    int errors = 0;
    int checks = 0;
    logic seen_p, seen_l;

    always #5 clk = ~clk;

    key_edge_detector dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig), .level_out(lvl), .pulse_out(pls),
        .pending(pnd), .overrun(ovr), .ack(ack), .any_pending(anyp)
    );

    key_edge_detector #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig2), .level_out(lvl2), .pulse_out(pls2),
        .pending(pnd2), .overrun(ovr2), .ack(ack2), .any_pending(anyp2)
    );

    key_edge_detector #(.NUM_CH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig3), .level_out(lvl3), .pulse_out(pls3),
        .pending(pnd3), .overrun(ovr3), .ack(ack3), .any_pending(anyp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sig = '0; ack = '0; sig2 = '0; ack2 = '0; sig3 = '0; ack3 = '0;
        tick(2);
        check("rst_level", 32'(lvl), 32'h0);
        check("rst_pulse", 32'(pls), 32'h0);
        check("rst_pending", 32'(pnd), 32'h0);
        check("rst_overrun", 32'(ovr), 32'h0);
        check("rst_any", 32'(anyp), 32'h0);

        // ch0 clean press: 18 edges to level/pulse, pending from edge 19
        rst_n = 1'b1;
        sig[0] = 1'b1;
        tick(17);
        check("ch0_lvl_e17", 32'(lvl[0]), 32'h0);
        check("ch0_pls_e17", 32'(pls[0]), 32'h0);
        tick(1);
        check("ch0_lvl_e18", 32'(lvl[0]), 32'h1);
        check("ch0_pls_e18", 32'(pls[0]), 32'h1);
        check("ch0_pnd_e18", 32'(pnd[0]), 32'h0);
        tick(1);
        check("ch0_pls_e19", 32'(pls[0]), 32'h0);
        check("ch0_pnd_e19", 32'(pnd[0]), 32'h1);
        check("ch0_any_e19", 32'(anyp), 32'h1);
        ack[0] = 1'b1;
        tick(1);
        ack[0] = 1'b0;
        check("ch0_ack_clr", 32'(pnd[0]), 32'h0);

        // ch1 glitch: 10 cycles high is not enough
        sig[1] = 1'b1;
        tick(10);
        sig[1] = 1'b0;
        seen_p = 1'b0; seen_l = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            seen_p |= pls[1];
            seen_l |= lvl[1];
        end
        check("ch1_glitch_pulse", 32'(seen_p), 32'h0);
        check("ch1_glitch_level", 32'(seen_l), 32'h0);
        check("ch1_cnt_zero", 32'(dut.g_ch[1].u_ch.cnt_q), 32'h0);

        // ch3: two presses without ack -> overrun, then ack clears all
        sig[3] = 1'b1;
        tick(18);
        check("ch3_press1", 32'(pls[3]), 32'h1);
        sig[3] = 1'b0;
        seen_p = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            seen_p |= pls[3];
        end
        check("ch3_fall_nopulse", 32'(seen_p), 32'h0);
        check("ch3_fall_level", 32'(lvl[3]), 32'h0);
        check("ch3_pnd_mid", 32'(pnd[3]), 32'h1);
        sig[3] = 1'b1;
        tick(18);
        check("ch3_press2", 32'(pls[3]), 32'h1);
        tick(1);
        check("ch3_overrun", 32'(ovr[3]), 32'h1);
        check("ch3_pending", 32'(pnd[3]), 32'h1);
        ack[3] = 1'b1;
        tick(1);
        ack[3] = 1'b0;
        check("ch3_ack_pnd", 32'(pnd[3]), 32'h0);
        check("ch3_ack_ovr", 32'(ovr[3]), 32'h0);
        check("ch3_ack_any", 32'(anyp), 32'h0);

        // ch4: ack coinciding with a second pulse keeps pending, no overrun
        sig[4] = 1'b1;
        tick(19);
        check("ch4_pnd1", 32'(pnd[4]), 32'h1);
        sig[4] = 1'b0;
        tick(20);
        sig[4] = 1'b1;
        tick(18);
        check("ch4_press2", 32'(pls[4]), 32'h1);
        ack[4] = 1'b1;
        tick(1);
        ack[4] = 1'b0;
        check("ch4_same_pnd", 32'(pnd[4]), 32'h1);
        check("ch4_same_ovr", 32'(ovr[4]), 32'h0);
        ack[4] = 1'b1;
        tick(1);
        ack[4] = 1'b0;
        check("ch4_final_clr", 32'(pnd[4]), 32'h0);

        // simultaneous presses on ch5..7
        sig[7:5] = 3'b111;
        tick(18);
        check("multi_pulse", 32'(pls), 32'he0);
        tick(1);
        check("multi_pending", 32'(pnd), 32'he0);

        // reset mid-debounce at count 10, input then held low
        sig[2] = 1'b1;
        tick(12);
        check("ch2_cnt10", 32'(dut.g_ch[2].u_ch.cnt_q), 32'd10);
        check("ch2_lvl_pre", 32'(lvl[2]), 32'h0);
        rst_n = 1'b0;
        sig = '0;
        #1;
        check("async_rst_lvl", 32'(lvl), 32'h0);
        check("async_rst_pnd", 32'(pnd), 32'h0);
        check("async_rst_any", 32'(anyp), 32'h0);
        check("async_rst_cnt", 32'(dut.g_ch[2].u_ch.cnt_q), 32'h0);
        tick(1);
        rst_n = 1'b1;
        seen_p = 1'b0; seen_l = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            seen_p |= |pls;
            seen_l |= |lvl;
        end
        check("post_rst_nopulse", 32'(seen_p), 32'h0);
        check("post_rst_nolevel", 32'(seen_l), 32'h0);

        // input held high through reset release reports a rising edge
        rst_n = 1'b0;
        sig[0] = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(17);
        check("hold_rst_e17", 32'(lvl[0]), 32'h0);
        tick(1);
        check("hold_rst_lvl", 32'(lvl[0]), 32'h1);
        check("hold_rst_pls", 32'(pls[0]), 32'h1);

        // both-edge mode, debounce 4: 6-edge latency each way
        sig2[2] = 1'b1;
        tick(5);
        check("b_press_e5", 32'(lvl2), 32'h0);
        tick(1);
        check("b_press_lvl", 32'(lvl2), 32'h4);
        check("b_press_pls", 32'(pls2), 32'h4);
        tick(1);
        check("b_press_pnd", 32'(pnd2), 32'h4);
        sig2[2] = 1'b0;
        tick(5);
        check("b_rel_e5", 32'(lvl2[2]), 32'h1);
        tick(1);
        check("b_rel_lvl", 32'(lvl2[2]), 32'h0);
        check("b_rel_pls", 32'(pls2[2]), 32'h1);
        tick(1);
        check("b_rel_ovr", 32'(ovr2[2]), 32'h1);

        // falling mode, 3 sync stages, debounce 1: 4-edge latency
        sig3 = 1'b1;
        tick(4);
        check("f_rise_lvl", 32'(lvl3), 32'h1);
        check("f_rise_nopls", 32'(pls3), 32'h0);
        sig3 = 1'b0;
        tick(3);
        check("f_fall_e3", 32'(lvl3), 32'h1);
        tick(1);
        check("f_fall_lvl", 32'(lvl3), 32'h0);
        check("f_fall_pls", 32'(pls3), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_edge_detector.md
KEY_EDGE_DETECTOR -- requirements
Module: key_edge_detector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8: number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (2..4).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change (1..65535).
REQ-004 The block SHALL have parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = both edges reported.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on posedge clk.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port sig_in, input, NUM_CH bits: raw asynchronous key/button levels.
REQ-008 The block SHALL have port level_out, output, NUM_CH bits: debounced stable level per channel.
REQ-009 The block SHALL have port pulse_out, output, NUM_CH bits: one-cycle qualifying-edge pulse per channel.
REQ-010 The block SHALL have port pending, output, NUM_CH bits: sticky event flag per channel.
REQ-011 The block SHALL have port overrun, output, NUM_CH bits: sticky flag for an event lost while pending.
REQ-012 The block SHALL have port ack, input, NUM_CH bits: per-channel clear of pending and overrun.
REQ-013 The block SHALL have port any_pending, output, 1 bit: OR of all pending bits.

Function
REQ-014 Each sig_in bit SHALL pass through a SYNC_STAGES flop chain; the last stage is the synced value.
REQ-015 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1) and a stable-level register.
REQ-016 At each edge where synced differs from stable, the counter SHALL increment; where they are equal, it SHALL clear to 0.
REQ-017 At the edge where the counter would reach DEBOUNCE_CYCLES, stable SHALL take the synced value and the counter SHALL clear.
REQ-018 A single-cycle mismatch shorter than DEBOUNCE_CYCLES (glitch) SHALL produce no change in level_out and no pulse.
REQ-019 level_out SHALL be the stable register directly, with no additional delay.
REQ-020 pulse_out SHALL be registered and high for exactly the one cycle in which level_out first shows the new value, if the change qualifies under EDGE_MODE.
REQ-021 Latency from a clean sig_in change, applied before edge 0, to level_out/pulse_out SHALL be SYNC_STAGES+DEBOUNCE_CYCLES edges (18 at defaults).
REQ-022 pending[i] SHALL set on the edge after pulse_out[i] and remain set until ack[i] is sampled high.
REQ-023 If ack[i] and a new pulse for channel i occur in the same cycle, pending[i] SHALL remain set and overrun[i] SHALL be cleared.
REQ-024 If pulse_out[i] is high while pending[i] is already set and ack[i] is low, overrun[i] SHALL set.
REQ-025 ack[i] while pending[i] is low SHALL have no effect.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-027 any_pending SHALL be combinational from the pending registers.

Reset
REQ-028 On rst_n low, the synchronizers, counters, stable levels, pulse_out, pending and overrun SHALL clear to 0 immediately, regardless of clk.
REQ-029 A sig_in held high through reset release SHALL be reported as a rising edge after REQ-021 latency.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count, with no pulse after release unless the input again satisfies the debounce.

Structure
REQ-031 The EDGE_MODE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2) SHALL live in shared package synth_input_pkg.
REQ-032 The per-channel synchronizer, debounce, edge and pending logic SHALL be sub-module debounce_channel, instantiated NUM_CH times by a generate loop.

Verification
REQ-033 With defaults, ch0 0->1 clean, held: level_out[0] and pulse_out[0] SHALL go high after edge 18, the pulse SHALL last 1 cycle, and pending[0] SHALL be high from edge 19.
REQ-034 With defaults, ch1 high for 10 cycles then low: there SHALL be no pulse, level_out[1] SHALL stay 0, and the counter SHALL return to 0.
REQ-035 With EDGE_MODE=2 and DEBOUNCE_CYCLES=4, a press then release of ch2 SHALL produce two pulses, and level_out SHALL follow each change after 6 edges.
REQ-036 Two presses with no ack SHALL set overrun[3]=1; then ack[3]=1 for 1 cycle SHALL give pending[3]=0, overrun[3]=0 and any_pending=0.
REQ-037 ack[4] in the same cycle as pulse_out[4] SHALL leave pending[4]=1 and overrun[4]=0.
REQ-038 rst_n low mid-debounce (count 10) and then released with input held low SHALL produce all outputs 0 and no pulse thereafter.
